// File: rtl/reaction_pkg.sv
// Shared types and constants for the reaction-timer stimulus front end.
package reaction_pkg;

  typedef enum logic [1:0] {IDLE, WAIT, GO, FALSE} state_t;

  localparam int unsigned LFSR_W    = 16;
  localparam int unsigned DELAY_W   = 9;
  localparam logic [LFSR_W-1:0] LFSR_SEED = 16'hACE1;
  localparam logic [LFSR_W-1:0] LFSR_TAPS = 16'hB400;

  // One step of the right-shifting Galois LFSR (x^16+x^14+x^13+x^11+1).
  function automatic logic [LFSR_W-1:0] lfsr_next(input logic [LFSR_W-1:0] s);
    return {1'b0, s[LFSR_W-1:1]} ^ (s[0] ? LFSR_TAPS : '0);
  endfunction

endpackage

// File: rtl/key_debounce.sv
// Raw active-low pushbutton -> synchronized, debounced level and one-cycle press pulse.
module key_debounce #(
  parameter int unsigned DB_CYCLES = 1000000
) (
  input  logic clk,
  input  logic rst_n,
  input  logic raw,
  output logic press
);

  localparam int unsigned CNT_W = $clog2(DB_CYCLES + 1);

  logic [1:0]       sync;
  logic             level;
  logic [CNT_W-1:0] cnt;

  // Level flips after DB_CYCLES consecutive synchronized samples disagreeing with it.
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      sync  <= 2'b11;
      level <= 1'b1;
      cnt   <= '0;
      press <= 1'b0;
    end else begin
      sync  <= {sync[0], raw};
      press <= 1'b0;
      if (sync[1] == level) begin
        cnt <= '0;
      end else if (cnt == CNT_W'(DB_CYCLES - 1)) begin
        cnt   <= '0;
        level <= sync[1];
        press <= ~sync[1];
      end else begin
        cnt <= cnt + CNT_W'(1);
      end
    end
  end

endmodule

// File: rtl/reaction_stimulus.sv
// Reaction-timer front end: debounced keys, random-delay stimulus LED, start/stop pulses.
// Optional false-start detection is built when REACTION_FALSE_START_EN is defined.
module reaction_stimulus
  import reaction_pkg::*;
#(
  parameter int unsigned TICK_DIV        = 500000,
  parameter int unsigned DB_CYCLES       = 1000000,
  parameter int unsigned MIN_DELAY_TICKS = 100
) (
  input  logic               clk,
  input  logic               key0,
  input  logic               key1,
  input  logic               key3,
  output logic               ledr,
  output logic               start_pulse,
  output logic               stop_pulse,
  output logic               false_start,
  output logic [DELAY_W-1:0] trial_delay
);

  localparam int unsigned TICK_W = (TICK_DIV > 1) ? $clog2(TICK_DIV) : 1;
`ifdef REACTION_FALSE_START_EN
  localparam bit FALSE_START_EN = 1'b1;
`else
  localparam bit FALSE_START_EN = 1'b0;
`endif

  logic               start_press;
  logic               react_press;
  logic [LFSR_W-1:0]  lfsr;
  state_t             state, state_nxt;
  logic [TICK_W-1:0]  tick_cnt, tick_cnt_nxt;
  logic [DELAY_W-1:0] delay_cnt, delay_cnt_nxt;
  logic [DELAY_W-1:0] trial_delay_nxt;
  logic               ledr_nxt, start_nxt, stop_nxt, false_nxt;
  logic               tick_c;
  logic [DELAY_W-1:0] load_c;

  key_debounce #(.DB_CYCLES(DB_CYCLES)) u_db_start (
    .clk   (clk),
    .rst_n (key0),
    .raw   (key1),
    .press (start_press)
  );

  key_debounce #(.DB_CYCLES(DB_CYCLES)) u_db_react (
    .clk   (clk),
    .rst_n (key0),
    .raw   (key3),
    .press (react_press)
  );

  always_ff @(posedge clk or negedge key0) begin
    if (!key0) lfsr <= LFSR_SEED;
    else       lfsr <= lfsr_next(lfsr);
  end

  assign tick_c = (state == WAIT) && (tick_cnt == TICK_W'(TICK_DIV - 1));
  assign load_c = DELAY_W'(MIN_DELAY_TICKS) + DELAY_W'(lfsr[7:0]);

  // Next-state, counters and registered outputs.
  always_comb begin
    state_nxt       = state;
    tick_cnt_nxt    = tick_cnt;
    delay_cnt_nxt   = delay_cnt;
    trial_delay_nxt = trial_delay;
    ledr_nxt        = ledr;
    start_nxt       = 1'b0;
    stop_nxt        = 1'b0;
    false_nxt       = false_start;
    unique case (state)
      IDLE, FALSE: begin
        if (start_press) begin
          state_nxt       = WAIT;
          delay_cnt_nxt   = load_c;
          trial_delay_nxt = load_c;
          tick_cnt_nxt    = '0;
          false_nxt       = 1'b0;
          ledr_nxt        = 1'b0;
        end
      end
      WAIT: begin
        tick_cnt_nxt = tick_c ? '0 : tick_cnt + TICK_W'(1);
        if (FALSE_START_EN && react_press) begin
          state_nxt = FALSE;
          false_nxt = 1'b1;
          ledr_nxt  = 1'b0;
        end else if (tick_c) begin
          if (delay_cnt == DELAY_W'(1)) begin
            state_nxt = GO;
            ledr_nxt  = 1'b1;
            start_nxt = 1'b1;
          end else begin
            delay_cnt_nxt = delay_cnt - DELAY_W'(1);
          end
        end
      end
      GO: begin
        if (react_press) begin
          state_nxt = IDLE;
          ledr_nxt  = 1'b0;
          stop_nxt  = 1'b1;
        end
      end
      default: state_nxt = IDLE;
    endcase
  end

  always_ff @(posedge clk or negedge key0) begin
    if (!key0) begin
      state       <= IDLE;
      tick_cnt    <= '0;
      delay_cnt   <= '0;
      trial_delay <= '0;
      ledr        <= 1'b0;
      start_pulse <= 1'b0;
      stop_pulse  <= 1'b0;
      false_start <= 1'b0;
    end else begin
      state       <= state_nxt;
      tick_cnt    <= tick_cnt_nxt;
      delay_cnt   <= delay_cnt_nxt;
      trial_delay <= trial_delay_nxt;
      ledr        <= ledr_nxt;
      start_pulse <= start_nxt;
      stop_pulse  <= stop_nxt;
      false_start <= false_nxt;
    end
  end

endmodule

// File: tb/tb_reaction_stimulus.sv
// Self-checking bench for reaction_stimulus with small timing parameters.
module tb_reaction_stimulus;

  localparam int TICK_DIV        = 4;
  localparam int DB_CYCLES       = 3;
  localparam int MIN_DELAY_TICKS = 2;
  localparam int PRESS_LAT       = 2 + DB_CYCLES;

  logic       clk = 1'b0;
  logic       key0, key1, key3;
  logic       ledr, start_pulse, stop_pulse, false_start;
  logic [8:0] trial_delay;

  int total = 0;
  int bad   = 0;
  int last_delay = 0;
  logic [15:0] m_lfsr;

  typedef struct {
    int len;
    bit also_react;
    bit exp_press;
  } vec_t;
  vec_t vecs[6];

  always #5 clk = ~clk;

  reaction_stimulus #(
    .TICK_DIV        (TICK_DIV),
    .DB_CYCLES       (DB_CYCLES),
    .MIN_DELAY_TICKS (MIN_DELAY_TICKS)
  ) dut (
    .clk         (clk),
    .key0        (key0),
    .key1        (key1),
    .key3        (key3),
    .ledr        (ledr),
    .start_pulse (start_pulse),
    .stop_pulse  (stop_pulse),
    .false_start (false_start),
    .trial_delay (trial_delay)
  );

  // Reference sequence: polynomial x^16+x^14+x^13+x^11+1, shift right, feedback from bit 0.
  function automatic logic [15:0] m_next(input logic [15:0] s);
    logic [15:0] r;
    r = s >> 1;
    if (s[0]) r = r ^ 16'hB400;
    return r;
  endfunction

  always @(posedge clk or negedge key0) begin
    if (!key0) m_lfsr <= 16'hACE1;
    else       m_lfsr <= m_next(m_lfsr);
  end

  task automatic check(input string name, input logic [31:0] act, input logic [31:0] exp);
    total++;
    if (act !== exp) begin
      bad++;
      $display("FAIL %s: got %0d want %0d", name, act, exp);
    end
  endtask

  task automatic idle(input int n);
    repeat (n) @(negedge clk);
  endtask

  // Hold key1 low for len (<=6) cycles; on return the bench sits in the WAIT-entry cycle.
  task automatic press_start(input int len, input bit also_react, input bit exp_press,
                             output int d);
    int cap;
    cap  = 0;
    key1 = 1'b0;
    if (also_react) key3 = 1'b0;
    for (int i = 1; i <= 6; i++) begin
      @(negedge clk);
      if (i == PRESS_LAT) cap = MIN_DELAY_TICKS + int'(m_lfsr[7:0]);
      if (i == len) begin
        key1 = 1'b1;
        key3 = 1'b1;
      end
    end
    key1 = 1'b1;
    key3 = 1'b1;
    if (exp_press) begin
      d = cap;
      last_delay = cap;
      check("trial_delay_load", 32'(trial_delay), 32'(cap));
      check("false_start_clear", 32'(false_start), 32'd0);
    end else begin
      d = last_delay;
      check("glitch_no_trial", 32'(trial_delay), 32'(last_delay));
    end
    check("ledr_low_at_wait", 32'(ledr), 32'd0);
  endtask

  // Wait for ledr; the rise must land d*TICK_DIV cycles after WAIT entry.
  task automatic wait_go(input int d, input int elapsed);
    int n;
    bit seen;
    n    = elapsed;
    seen = 1'b0;
    while (!seen && n < d * TICK_DIV + 16) begin
      @(negedge clk);
      n++;
      if (ledr) seen = 1'b1;
    end
    check("go_latency", seen ? 32'(n) : 32'hFFFF_FFFF, 32'(d * TICK_DIV));
    check("start_pulse_on_rise", 32'(start_pulse), 32'd1);
    check("stop_with_start", 32'(stop_pulse), 32'd0);
    @(negedge clk);
    check("start_pulse_width", 32'(start_pulse), 32'd0);
    check("ledr_hold", 32'(ledr), 32'd1);
  endtask

  task automatic react(input int gap);
    int early;
    early = 0;
    repeat (gap) @(negedge clk);
    key3 = 1'b0;
    for (int i = 1; i <= PRESS_LAT; i++) begin
      @(negedge clk);
      if (stop_pulse) early++;
    end
    check("stop_not_early", 32'(early), 32'd0);
    check("ledr_before_stop", 32'(ledr), 32'd1);
    @(negedge clk);
    key3 = 1'b1;
    check("stop_pulse", 32'(stop_pulse), 32'd1);
    check("ledr_off", 32'(ledr), 32'd0);
    @(negedge clk);
    check("stop_pulse_width", 32'(stop_pulse), 32'd0);
  endtask

  initial begin
    int d;
    int cnt;
    int lost;
    int len;
    bit also;

    vecs[0] = '{len: 1, also_react: 1'b0, exp_press: 1'b0};
    vecs[1] = '{len: 2, also_react: 1'b0, exp_press: 1'b0};
    vecs[2] = '{len: 2, also_react: 1'b1, exp_press: 1'b0};
    vecs[3] = '{len: 3, also_react: 1'b0, exp_press: 1'b1};
    vecs[4] = '{len: 6, also_react: 1'b1, exp_press: 1'b1};
    vecs[5] = '{len: 4, also_react: 1'b0, exp_press: 1'b1};

    // Reset held with keys toggling: everything stays at zero.
    key0 = 1'b0;
    key1 = 1'b1;
    key3 = 1'b1;
    for (int i = 0; i < 8; i++) begin
      @(negedge clk);
      check("reset_outputs", 32'({ledr, start_pulse, stop_pulse, false_start, trial_delay}), 32'd0);
      key1 = 1'($urandom_range(0, 1));
      key3 = 1'($urandom_range(0, 1));
    end
    key1 = 1'b1;
    key3 = 1'b1;
    idle(2);
    key0 = 1'b1;

    // First press begins in the first cycle after release, exposing the seed.
    press_start(6, 1'b0, 1'b1, d);
    wait_go(d, 0);
    react(1);
    idle(8);

    // Debounce / simultaneous-press table.
    foreach (vecs[i]) begin
      press_start(vecs[i].len, vecs[i].also_react, vecs[i].exp_press, d);
      if (vecs[i].exp_press) begin
        wait_go(d, 0);
        react(int'($urandom_range(0, 6)));
      end
      idle(8);
    end

    // React press during WAIT.
    press_start(6, 1'b0, 1'b1, d);
    key3 = 1'b0;
    repeat (6) @(negedge clk);
    key3 = 1'b1;
    @(negedge clk);
`ifdef REACTION_FALSE_START_EN
    check("false_start_set", 32'(false_start), 32'd1);
    check("ledr_false", 32'(ledr), 32'd0);
    cnt  = 0;
    lost = 0;
    repeat (2000) begin
      @(negedge clk);
      if (ledr || start_pulse) cnt++;
      if (!false_start) lost++;
    end
    check("ledr_stays_low", 32'(cnt), 32'd0);
    check("false_start_held", 32'(lost), 32'd0);
    press_start(6, 1'b0, 1'b1, d);
    wait_go(d, 0);
    react(2);
`else
    check("false_start_tied", 32'(false_start), 32'd0);
    check("ledr_false", 32'(ledr), 32'd0);
    wait_go(d, 7);
    react(3);
`endif
    idle(8);

    // Reset while the LED is lit.
    press_start(5, 1'b0, 1'b1, d);
    wait_go(d, 0);
    #2 key0 = 1'b0;
    #1;
    check("reset_ledr_async", 32'(ledr), 32'd0);
    check("reset_pulses", 32'({start_pulse, stop_pulse}), 32'd0);
    @(negedge clk);
    check("reset_trial_delay", 32'(trial_delay), 32'd0);
    key0 = 1'b1;
    last_delay = 0;
    idle(2);
    key3 = 1'b0;
    cnt = 0;
    for (int i = 0; i < 16; i++) begin
      @(negedge clk);
      if (i == 5) key3 = 1'b1;
      if (ledr || stop_pulse || start_pulse) cnt++;
    end
    check("react_ignored_after_reset", 32'(cnt), 32'd0);
    check("no_trial_after_reset", 32'(trial_delay), 32'd0);

    // Randomized trials against the reference model.
    for (int t = 0; t < 8; t++) begin
      len  = int'($urandom_range(1, 6));
      also = 1'($urandom_range(0, 1));
      press_start(len, also, len >= 3, d);
      if (len >= 3) begin
        wait_go(d, 0);
        react(int'($urandom_range(0, 8)));
      end
      idle(int'($urandom_range(6, 12)));
    end

    $display("test done: total=%0d bad=%0d", total, bad);
    $finish;
  end

endmodule

// File: doc/reaction_stimulus.md
# reaction_stimulus

Front end of the reaction-timer lab design; sits directly upstream of the elapsed-time measurement stage. It debounces the start (key1) and react (key3) pushbuttons, then waits a pseudo-random delay after each start press. When the delay expires it lights the stimulus LED and issues one-cycle start/stop pulses that bracket the measured interval. Presses on the react button before the LED lights are flagged as false starts.

## Interface
- TICK_DIV, 500000: clk cycles per 10 ms tick (50 MHz).
- DB_CYCLES, 1000000: cycles a raw key must be stable to be accepted (20 ms).
- MIN_DELAY_TICKS, 100: fixed part of stimulus delay in ticks; legal range 1..256.
- clk  in  1  system clock, all logic on rising edge.
- key0  in  1  reset; asynchronous, active-low.
- key1  in  1  start button, raw, active-low.
- key3  in  1  react button, raw, active-low.
- ledr  out  1  stimulus LED; 1 while the measurement interval is open.
- start_pulse  out  1  one-cycle pulse on the cycle ledr rises.
- stop_pulse  out  1  one-cycle pulse on the accepted react press.
- false_start  out  1  level; react pressed before stimulus.
- trial_delay  out  9  delay in ticks loaded for the current or most recent trial.

## Operation
- Debounce: 2-FF synchronizer, then a counter. The clean level flips after DB_CYCLES consecutive cycles of the opposite raw value. A press pulse is one cycle, on the clean 1→0 transition.
- LFSR: 16-bit Galois LFSR, taps x^16+x^14+x^13+x^11+1, seed 16'hACE1. It advances every cycle and never reaches zero.
- FSM states: IDLE, WAIT, GO, FALSE.
- IDLE: a start press loads delay = MIN_DELAY_TICKS + lfsr[7:0] into the down-counter and into trial_delay, clears the tick counter, and moves to WAIT. React presses are ignored.
- WAIT: the down-counter decrements on each tick. A tick that finds the counter at 1 moves to GO, sets ledr=1 and pulses start_pulse. Start presses are ignored.
- GO: a react press clears ledr, pulses stop_pulse and moves to IDLE. Start presses are ignored.
- FALSE: false_start=1 and ledr=0. A start press clears false_start and starts a new trial exactly as from IDLE.
- Widths: delay counter 9 bits, max 511. Tick counter is ceil(log2(TICK_DIV)) bits and wraps at TICK_DIV-1.

## Timing
- Reset values: ledr=0, start_pulse=0, stop_pulse=0, false_start=0, trial_delay=0, state IDLE, LFSR=16'hACE1, all counters 0. Debounced levels reset to released (1).
- Reset mid-trial clears everything immediately and asynchronously. No pulse is emitted on reset exit.
- Press latency: a raw edge produces its press pulse 2+DB_CYCLES cycles later.
- Tick: first tick comes TICK_DIV cycles after WAIT entry, then every TICK_DIV cycles.
- WAIT→GO: ledr rises exactly trial_delay×TICK_DIV cycles after the WAIT-entry cycle.
- Pulses: start_pulse and stop_pulse are high for exactly one cycle each.
- Simultaneous events:
  - Start and react pressed in the same cycle in IDLE: start wins.
  - React press on the same cycle as the final WAIT tick: treated as in WAIT (see Configuration).
- Minimum measured interval: stop_pulse is never in the same cycle as start_pulse; the earliest is the following cycle.

## Configuration
- REACTION_FALSE_START_EN defined: a react press in WAIT moves to FALSE, sets false_start=1 and never raises ledr.
- Not defined: react presses in WAIT are ignored, false_start is tied 0, and the FALSE state is unreachable and may be removed.

## Structure
- Package reaction_pkg: state enum (IDLE, WAIT, GO, FALSE), LFSR_SEED=16'hACE1, LFSR_TAPS=16'hB400, DELAY_W=9.
- Sub-module key_debounce (synchronizer, stability counter, clean level, press pulse), parameterised by DB_CYCLES. Instantiated for key1 and key3.
- FSM, LFSR, tick divider and delay counter live in reaction_stimulus.

## Test plan
Bench parameters: TICK_DIV=4, DB_CYCLES=3, MIN_DELAY_TICKS=2.
- Reset: hold key0=0 with keys toggling → all outputs 0; after release, LFSR=16'hACE1 in the first cycle.
- Debounce: key1 glitches low for 2 cycles → no trial. key1 held low for 6 cycles → exactly one press, 5 cycles after the edge; WAIT entered.
- Normal trial: start press → trial_delay = 2 + lfsr[7:0] (checked against a model); ledr and start_pulse rise exactly trial_delay×4 cycles later. React press → ledr=0 and stop_pulse for one cycle.
- False start (macro on): react press in WAIT → false_start=1 and ledr stays 0 for 2000 cycles. Next start press → false_start=0 and a new trial begins.
- False start (macro off): same stimulus → false_start=0 and ledr rises on schedule.
- Mid-trial reset: assert key0 while in GO → ledr=0 immediately and no stop_pulse. After release, react presses are ignored until a start press.
